// File: rtl/mfu_psum_accumulator.sv
// mfu_psum_accumulator: unpacks multiplier product words into per-lane sums and drains them serially.
module mfu_psum_accumulator #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_p,
  input  logic [1:0]       in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;
  state_t           state;
  logic [1:0]       mode_q, lane, last_lane;
  logic [ACC_W-1:0] acc [4];
  logic [ACC_W-1:0] add [4];
  logic             accept, hit, drain_done;
  assign in_ready   = state != DRAIN;
  assign accept     = in_valid & in_ready;
  assign hit        = accept & (in_mode != 2'b00) & (state == IDLE | in_mode == mode_q);
  assign last_lane  = mode_q == 2'b11 ? 2'd3 : mode_q == 2'b10 ? 2'd1 : 2'd0;
  assign out_valid  = state == DRAIN;
  assign out_data   = acc[lane];
  assign out_lane   = lane;
  assign out_last   = out_valid & (lane == last_lane);
  assign drain_done = out_valid & out_ready & out_last;
  // Lane 0 is always the most-significant field; fields of unused lanes add zero.
  always_comb begin
    add[0] = in_mode == 2'b01 ? ACC_W'($signed(in_p[15:0])) :
             in_mode == 2'b10 ? ACC_W'($signed(in_p[15:8])) :
             in_mode == 2'b11 ? ACC_W'($signed(in_p[15:12])) : '0;
    add[1] = in_mode == 2'b10 ? ACC_W'($signed(in_p[7:0])) :
             in_mode == 2'b11 ? ACC_W'($signed(in_p[11:8])) : '0;
    add[2] = in_mode == 2'b11 ? ACC_W'($signed(in_p[7:4])) : '0;
    add[3] = in_mode == 2'b11 ? ACC_W'($signed(in_p[3:0])) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= 2'b00;
      lane   <= 2'd0;
      err    <= 1'b0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else begin
      unique case (state)
        IDLE: if (hit) begin
          mode_q <= in_mode;
          state  <= in_last ? DRAIN : ACC;
        end
        ACC: if (accept) begin
          err <= err | (in_mode != 2'b00 && in_mode != mode_q);
          if (in_last) state <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          lane <= drain_done ? 2'd0 : lane + 2'd1;
          if (drain_done) begin
            mode_q <= 2'b00;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      for (int i = 0; i < 4; i++) acc[i] <= drain_done ? '0 : hit ? acc[i] + add[i] : acc[i];
    end
  end
endmodule

// File: tb/tb_mfu_psum_accumulator.sv
// tb_mfu_psum_accumulator: directed scenario bench for mfu_psum_accumulator.
module tb_mfu_psum_accumulator;
  localparam int ACC_W = 24;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_p = '0;
  logic [1:0]       in_mode = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_data;
  logic [1:0]       out_lane;
  logic             out_last;
  logic             err;
  int vectors = 0;
  int miscompares = 0;
  mfu_psum_accumulator #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .out_last(out_last), .err(err)
  );
  always #5 clk = ~clk;
  // Inputs change and outputs are observed on the falling edge.
  task automatic send(input logic [15:0] p, input logic [1:0] m, input logic l);
    in_valid = 1'b1; in_p = p; in_mode = m; in_last = l;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask
  task automatic drain_lane(input string name, input logic [ACC_W-1:0] d, input logic [1:0] ln, input logic lst);
    vectors++;
    if ({out_valid, out_data, out_lane, out_last, in_ready} !== {1'b1, d, ln, lst, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: got valid=%b data=%h lane=%0d last=%b in_ready=%b, want valid=1 data=%h lane=%0d last=%b in_ready=0",
               name, out_valid, out_data, out_lane, out_last, in_ready, d, ln, lst);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask
  task automatic test_idle_after(input string name, input logic e);
    vectors++;
    if ({out_valid, in_ready, err} !== {1'b0, 1'b1, e}) begin
      miscompares++;
      $display("FAIL %s: got out_valid=%b in_ready=%b err=%b, want 0 1 %b", name, out_valid, in_ready, err, e);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, out_data, out_lane, out_last, err} !== {1'b1, 1'b0, 24'h0, 2'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b data=%h lane=%0d last=%b err=%b, want 1 0 000000 0 0 0",
               in_ready, out_valid, out_data, out_lane, out_last, err);
    end
  endtask
  task automatic test_noop_idle();
    send(16'h1234, 2'b00, 1'b1);
    test_idle_after("noop_idle_dropped", 1'b0);
    @(posedge clk); @(negedge clk);
    test_idle_after("noop_idle_still", 1'b0);
  endtask
  task automatic test_mode01();
    send(16'h0010, 2'b01, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL m01_no_early_valid: got %b, want 0", out_valid);
    end
    send(16'hFFF0, 2'b01, 1'b0);
    send(16'h0003, 2'b01, 1'b1);
    drain_lane("m01_lane0", 24'h000003, 2'd0, 1'b1);
    test_idle_after("m01_done", 1'b0);
  endtask
  task automatic test_mode10();
    send(16'h05FE, 2'b10, 1'b0);
    send(16'h05FE, 2'b10, 1'b1);
    drain_lane("m10_lane0", 24'h00000A, 2'd0, 1'b0);
    drain_lane("m10_lane1", 24'hFFFFFC, 2'd1, 1'b1);
    test_idle_after("m10_done", 1'b0);
  endtask
  task automatic test_mode11_backpressure();
    send(16'h7F81, 2'b11, 1'b0);
    send(16'h7F81, 2'b11, 1'b0);
    send(16'h7F81, 2'b11, 1'b1);
    drain_lane("m11_lane0", 24'h000015, 2'd0, 1'b0);
    drain_lane("m11_lane1", 24'hFFFFFD, 2'd1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_p = 16'h1111; in_mode = 2'b11; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if ({out_valid, out_data, out_lane, out_last, in_ready} !== {1'b1, 24'hFFFFE8, 2'd2, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL m11_stall%0d: got valid=%b data=%h lane=%0d last=%b in_ready=%b, want 1 ffffe8 2 0 0",
                 i, out_valid, out_data, out_lane, out_last, in_ready);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    drain_lane("m11_lane2", 24'hFFFFE8, 2'd2, 1'b0);
    drain_lane("m11_lane3", 24'h000003, 2'd3, 1'b1);
    test_idle_after("m11_done", 1'b0);
  endtask
  task automatic test_mismatch();
    send(16'h05FE, 2'b10, 1'b0);
    send(16'h1234, 2'b01, 1'b0);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL mismatch_err: got %b, want 1", err);
    end
    send(16'h05FE, 2'b10, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mismatch_no_drain: got out_valid=%b, want 0", out_valid);
    end
    send(16'hFFFF, 2'b00, 1'b1);
    drain_lane("mismatch_lane0", 24'h00000A, 2'd0, 1'b0);
    drain_lane("mismatch_lane1", 24'hFFFFFC, 2'd1, 1'b1);
    test_idle_after("mismatch_sticky", 1'b1);
  endtask
  task automatic test_reset_mid_drain();
    send(16'h05FE, 2'b10, 1'b1);
    drain_lane("rst_lane0", 24'h000005, 2'd0, 1'b0);
    vectors++;
    if ({out_valid, out_lane} !== {1'b1, 2'd1}) begin
      miscompares++;
      $display("FAIL rst_pre_lane1: got valid=%b lane=%0d, want 1 1", out_valid, out_lane);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({out_valid, in_ready, err, out_data, out_lane} !== {1'b0, 1'b1, 1'b0, 24'h0, 2'd0}) begin
      miscompares++;
      $display("FAIL rst_mid_drain: got valid=%b in_ready=%b err=%b data=%h lane=%0d, want 0 1 0 000000 0",
               out_valid, in_ready, err, out_data, out_lane);
    end
    send(16'h0007, 2'b01, 1'b1);
    drain_lane("rst_new_group", 24'h000007, 2'd0, 1'b1);
    test_idle_after("rst_new_done", 1'b0);
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_noop_idle();
    test_mode01();
    test_mode10();
    test_mode11_backpressure();
    test_mismatch();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
